// File: rtl/bram_to_stream_framer_if.sv
// AXI4-Stream bundle carried from the BRAM sequence framer to the DAC/filter chain.
interface bram_to_stream_framer_if #(
  parameter int DATA_W = 48
) ();
  logic                TVALID;
  logic [DATA_W-1:0]   TDATA;
  logic [DATA_W/8-1:0] TSTRB;
  logic                TLAST;
  logic                TREADY;

  modport master (output TVALID, output TDATA, output TSTRB, output TLAST, input TREADY);
  modport slave  (input TVALID, input TDATA, input TSTRB, input TLAST, output TREADY);
endinterface

// File: rtl/bram_to_stream_framer.sv
// Reads complex words from a 1-cycle BRAM, appends a zero-pad tail and frames them
// onto AXI-Stream with TLAST; one-shot or continuous runs with START/STOP control.
module bram_to_stream_framer #(
  parameter int BRAM_DEPTH_BITS      = 10,
  parameter int BRAM_TDATA_WIDTH     = 64,
  parameter int SAMPLE_BITS          = 23,
  parameter int C_M_AXIS_TDATA_WIDTH = 48,
  parameter int PAD_LEN_BITS         = 8
) (
  input  logic                         M_AXIS_ACLK,
  input  logic                         M_AXIS_ARESETN,
  input  logic                         START,
  input  logic                         STOP,
  input  logic                         CFG_CONTINUOUS,
  input  logic [BRAM_DEPTH_BITS:0]     CFG_FRAME_LEN,
  input  logic [PAD_LEN_BITS-1:0]      CFG_PAD_LEN,
  output logic                         BUSY,
  output logic                         DONE,
  output logic [15:0]                  FRAME_CNT,
  output logic [BRAM_DEPTH_BITS-1:0]   BRAM_ADDR,
  output logic                         BRAM_EN,
  input  logic [BRAM_TDATA_WIDTH-1:0]  BRAM_DATAIN,
  bram_to_stream_framer_if.master      m_axis
);

  localparam int FL_W   = BRAM_DEPTH_BITS + 1;
  localparam int HALF_W = C_M_AXIS_TDATA_WIDTH / 2;
  localparam int ZX_W   = HALF_W - SAMPLE_BITS;
  localparam int DW     = C_M_AXIS_TDATA_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_PAD  = 2'd2;

  localparam logic [FL_W-1:0]            FL_ONE   = FL_W'(1);
  localparam logic [PAD_LEN_BITS-1:0]    PAD_ONE  = PAD_LEN_BITS'(1);
  localparam logic [BRAM_DEPTH_BITS-1:0] ADDR_ONE = BRAM_DEPTH_BITS'(1);

  logic [1:0]                 state_reg;
  logic [BRAM_DEPTH_BITS-1:0] addr_reg;
  logic [FL_W-1:0]            data_cnt_reg;
  logic [PAD_LEN_BITS-1:0]    pad_cnt_reg;
  logic [FL_W-1:0]            frame_len_reg;
  logic [PAD_LEN_BITS-1:0]    pad_len_reg;
  logic                       cont_reg;
  logic                       stop_pending_reg;
  logic                       busy_reg;
  logic                       done_reg;
  logic [15:0]                frame_cnt_reg;

  // Beat in flight: issued last cycle, its data (if any) is on BRAM_DATAIN now.
  logic stg_valid_reg, stg_pad_reg, stg_last_reg, stg_final_reg;

  // Two-entry output buffer: out_* drives the stream, skid_* holds the overflow beat.
  logic          out_valid_reg, out_last_reg, out_final_reg;
  logic [DW-1:0] out_data_reg;
  logic          skid_valid_reg, skid_last_reg, skid_final_reg;
  logic [DW-1:0] skid_data_reg;

  logic          pop, can_capture, push, advance, in_frame, issue;
  logic          last_data, last_pad, pad_zero, issue_last, restart;
  logic [DW-1:0] stg_data;
  logic          unused_bits;

  assign pop         = out_valid_reg && m_axis.TREADY;
  assign can_capture = !(out_valid_reg && skid_valid_reg) || pop;
  assign push        = stg_valid_reg && can_capture;
  // A stalled in-flight word stays parked on the BRAM output because BRAM_EN stays low.
  assign advance     = !stg_valid_reg || can_capture;
  assign in_frame    = (state_reg == ST_DATA) || (state_reg == ST_PAD);
  assign issue       = in_frame && advance;

  assign last_data  = (data_cnt_reg == frame_len_reg - FL_ONE);
  assign last_pad   = (pad_cnt_reg == pad_len_reg - PAD_ONE);
  assign pad_zero   = (pad_len_reg == '0);
  assign issue_last = (state_reg == ST_DATA) ? (last_data && pad_zero) : last_pad;
  // Restart is decided when the frame's last beat is issued; a STOP seen by then ends the run.
  assign restart    = cont_reg && !stop_pending_reg && !STOP;

  assign stg_data = stg_pad_reg ? '0 :
                    {{ZX_W{1'b0}}, BRAM_DATAIN[32+SAMPLE_BITS-1:32],
                     {ZX_W{1'b0}}, BRAM_DATAIN[SAMPLE_BITS-1:0]};
  assign unused_bits = ^{BRAM_DATAIN[31:SAMPLE_BITS],
                         BRAM_DATAIN[BRAM_TDATA_WIDTH-1:32+SAMPLE_BITS]};

  assign BRAM_EN   = issue && (state_reg == ST_DATA);
  assign BRAM_ADDR = addr_reg;
  assign BUSY      = busy_reg;
  assign DONE      = done_reg;
  assign FRAME_CNT = frame_cnt_reg;

  assign m_axis.TVALID = out_valid_reg;
  assign m_axis.TDATA  = out_data_reg;
  assign m_axis.TLAST  = out_last_reg;
  assign m_axis.TSTRB  = '1;

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_reg        <= ST_IDLE;
      addr_reg         <= '0;
      data_cnt_reg     <= '0;
      pad_cnt_reg      <= '0;
      frame_len_reg    <= '0;
      pad_len_reg      <= '0;
      cont_reg         <= 1'b0;
      stop_pending_reg <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      frame_cnt_reg    <= '0;
    end else begin
      done_reg <= 1'b0;
      if (busy_reg && STOP) stop_pending_reg <= 1'b1;

      if (pop && out_last_reg) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
        if (out_final_reg) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end

      case (state_reg)
        ST_IDLE: begin
          if (START && !busy_reg && ((CFG_FRAME_LEN != '0) || (CFG_PAD_LEN != '0))) begin
            frame_len_reg    <= CFG_FRAME_LEN;
            pad_len_reg      <= CFG_PAD_LEN;
            cont_reg         <= CFG_CONTINUOUS;
            stop_pending_reg <= 1'b0;
            busy_reg         <= 1'b1;
            addr_reg         <= '0;
            data_cnt_reg     <= '0;
            pad_cnt_reg      <= '0;
            state_reg        <= (CFG_FRAME_LEN != '0) ? ST_DATA : ST_PAD;
          end
        end
        ST_DATA: begin
          if (issue) begin
            if (last_data) begin
              addr_reg     <= '0;
              data_cnt_reg <= '0;
              if (!pad_zero)     state_reg <= ST_PAD;
              else if (!restart) state_reg <= ST_IDLE;
            end else begin
              addr_reg     <= addr_reg + ADDR_ONE;
              data_cnt_reg <= data_cnt_reg + FL_ONE;
            end
          end
        end
        ST_PAD: begin
          if (issue) begin
            if (last_pad) begin
              pad_cnt_reg <= '0;
              if (!restart)                  state_reg <= ST_IDLE;
              else if (frame_len_reg != '0)  state_reg <= ST_DATA;
            end else begin
              pad_cnt_reg <= pad_cnt_reg + PAD_ONE;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      stg_valid_reg <= 1'b0;
      stg_pad_reg   <= 1'b0;
      stg_last_reg  <= 1'b0;
      stg_final_reg <= 1'b0;
    end else if (advance) begin
      stg_valid_reg <= issue;
      stg_pad_reg   <= (state_reg == ST_PAD);
      stg_last_reg  <= issue_last;
      stg_final_reg <= issue_last && !restart;
    end
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_last_reg   <= 1'b0;
      out_final_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_last_reg  <= 1'b0;
      skid_final_reg <= 1'b0;
    end else begin
      if (pop && skid_valid_reg) begin
        out_valid_reg  <= 1'b1;
        out_data_reg   <= skid_data_reg;
        out_last_reg   <= skid_last_reg;
        out_final_reg  <= skid_final_reg;
        skid_valid_reg <= push;
        if (push) begin
          skid_data_reg  <= stg_data;
          skid_last_reg  <= stg_last_reg;
          skid_final_reg <= stg_final_reg;
        end
      end else if (pop || !out_valid_reg) begin
        out_valid_reg <= push;
        if (push) begin
          out_data_reg  <= stg_data;
          out_last_reg  <= stg_last_reg;
          out_final_reg <= stg_final_reg;
        end
      end else if (push) begin
        skid_valid_reg <= 1'b1;
        skid_data_reg  <= stg_data;
        skid_last_reg  <= stg_last_reg;
        skid_final_reg <= stg_final_reg;
      end
    end
  end

endmodule

// File: tb/tb_bram_to_stream_framer.sv
// Directed and randomized checks of the BRAM-to-stream framer against a beat-list model.
module tb_bram_to_stream_framer;
  localparam int AW = 10;
  localparam int BW = 64;
  localparam int DW = 48;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          cfg_cont = 1'b0;
  logic [AW:0]   cfg_flen = '0;
  logic [PW-1:0] cfg_plen = '0;
  logic          busy, done, bram_en;
  logic [15:0]   frame_cnt;
  logic [AW-1:0] bram_addr;
  logic [BW-1:0] bram_dout;

  logic [BW-1:0] mem [0:(1<<AW)-1];
  logic [DW:0]   exp_q [$];
  int checks = 0;
  int errors = 0;
  int exp_frames = 0;
  int done_cnt = 0;
  int first_cyc = -1;
  int last_cyc = -1;

  always #5 clk = ~clk;

  bram_to_stream_framer_if #(.DATA_W(DW)) axis_if ();

  bram_to_stream_framer dut (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (rst_n),
    .START          (start),
    .STOP           (stop),
    .CFG_CONTINUOUS (cfg_cont),
    .CFG_FRAME_LEN  (cfg_flen),
    .CFG_PAD_LEN    (cfg_plen),
    .BUSY           (busy),
    .DONE           (done),
    .FRAME_CNT      (frame_cnt),
    .BRAM_ADDR      (bram_addr),
    .BRAM_EN        (bram_en),
    .BRAM_DATAIN    (bram_dout),
    .m_axis         (axis_if)
  );

  // Block RAM with 1-cycle read latency; output holds while enable is low.
  always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Model: every frame is flen data words from address 0 followed by plen zero beats.
  function automatic void push_frames(input int flen, input int plen, input int nf);
    for (int f = 0; f < nf; f++) begin
      for (int b = 0; b < flen + plen; b++) begin
        logic [DW-1:0] d;
        if (b < flen) d = {1'b0, mem[b][54:32], 1'b0, mem[b][22:0]};
        else          d = '0;
        exp_q.push_back({(b == flen + plen - 1), d});
      end
    end
  endfunction

  task automatic start_run(input logic cont, input int flen, input int plen);
    @(negedge clk);
    cfg_cont = cont;
    cfg_flen = flen[AW:0];
    cfg_plen = plen[PW-1:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
  endtask

  // rmode: 0 = always ready, 1 = ready pattern 1,0,0,1, 2 = random ready.
  task automatic collect(input int nbeats, input int rmode, input int stop_at);
    int got = 0;
    int cyc = 0;
    int limit = nbeats * 6 + 40;
    logic held = 1'b0;
    logic [DW-1:0] held_data = '0;
    logic held_last = 1'b0;
    logic [DW:0] e;
    first_cyc = -1;
    last_cyc = -1;
    while (got < nbeats && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (held) begin
        chk("hold_tvalid", axis_if.TVALID, 1);
        chk("hold_tdata", axis_if.TDATA, held_data);
        chk("hold_tlast", axis_if.TLAST, held_last);
      end
      case (rmode)
        0:       axis_if.TREADY = 1'b1;
        1:       axis_if.TREADY = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
        default: axis_if.TREADY = 1'($urandom_range(0, 1));
      endcase
      stop = (stop_at >= 0) && (got == stop_at);
      if (done) done_cnt++;
      if (axis_if.TVALID && first_cyc < 0) first_cyc = cyc;
      if (axis_if.TVALID && axis_if.TREADY) begin
        chk("model_has_beat", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("tdata", axis_if.TDATA, e[DW-1:0]);
          chk("tlast", axis_if.TLAST, e[DW]);
        end
        got++;
        last_cyc = cyc;
      end
      held = axis_if.TVALID && !axis_if.TREADY;
      held_data = axis_if.TDATA;
      held_last = axis_if.TLAST;
    end
    stop = 1'b0;
    chk("beat_count", got, nbeats);
  endtask

  task automatic check_end();
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
      chk("no_extra_tvalid", axis_if.TVALID, 0);
    end
    chk("done_pulses", done_cnt, 1);
    chk("busy_low", busy, 0);
    chk("frame_cnt", frame_cnt, exp_frames);
    chk("model_drained", exp_q.size(), 0);
  endtask

  initial begin
    axis_if.TREADY = 1'b0;
    for (int i = 0; i < (1 << AW); i++)
      mem[i] = {9'h0, 23'h7FFFFF, 9'h0, 23'(i + 1)};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_tvalid", axis_if.TVALID, 0);
    chk("rst_tlast", axis_if.TLAST, 0);
    chk("rst_tdata", axis_if.TDATA, 0);
    chk("rst_bram_en", bram_en, 0);
    chk("rst_bram_addr", bram_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("tstrb", axis_if.TSTRB, 64'h3F);
    rst_n = 1'b1;

    // One-shot 4+2, always ready: latency and gap-free delivery
    push_frames(4, 2, 1);
    exp_frames += 1;
    start_run(1'b0, 4, 2);
    chk("start_bram_en", bram_en, 1);
    chk("start_bram_addr", bram_addr, 0);
    chk("start_busy", busy, 1);
    chk("start_tvalid", axis_if.TVALID, 0);
    collect(6, 0, -1);
    chk("first_valid_latency", first_cyc, 2);
    chk("gapfree_oneshot", last_cyc - first_cyc + 1, 6);
    check_end();

    // Same frame under 1,0,0,1 backpressure
    push_frames(4, 2, 1);
    exp_frames += 1;
    start_run(1'b0, 4, 2);
    collect(6, 1, -1);
    check_end();

    // No pad, then pad only
    push_frames(3, 0, 1);
    exp_frames += 1;
    start_run(1'b0, 3, 0);
    collect(3, 0, -1);
    check_end();
    push_frames(0, 5, 1);
    exp_frames += 1;
    start_run(1'b0, 0, 5);
    collect(5, 0, -1);
    chk("gapfree_padonly", last_cyc - first_cyc + 1, 5);
    check_end();

    // Both lengths zero: START ignored
    start_run(1'b0, 0, 0);
    repeat (3) begin
      @(negedge clk);
      chk("zero_busy", busy, 0);
      chk("zero_bram_en", bram_en, 0);
      chk("zero_tvalid", axis_if.TVALID, 0);
    end

    // Randomized one-shot frames with random backpressure and random BRAM contents
    for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom};
    for (int it = 0; it < 6; it++) begin
      int fl = $urandom_range(0, 40);
      int pl = $urandom_range((fl == 0) ? 1 : 0, 6);
      push_frames(fl, pl, 1);
      exp_frames += 1;
      start_run(1'b0, fl, pl);
      collect(fl + pl, 2, -1);
      check_end();
    end

    // Continuous full-depth frames, STOP in the middle of frame 3
    push_frames(1024, 32, 3);
    exp_frames += 3;
    start_run(1'b1, 1024, 32);
    collect(3168, 0, 2 * 1056 + 500);
    chk("gapfree_continuous", last_cyc - first_cyc + 1, 3168);
    check_end();

    // Config change while busy must not affect the running sequence
    push_frames(4, 2, 3);
    exp_frames += 3;
    start_run(1'b1, 4, 2);
    cfg_flen = 11'd8;
    collect(18, 2, 13);
    check_end();

    // Asynchronous reset in the middle of a continuous run
    push_frames(4, 2, 1);
    start_run(1'b1, 4, 2);
    collect(3, 0, -1);
    @(negedge clk);
    axis_if.TREADY = 1'b0;
    chk("pre_reset_tvalid", axis_if.TVALID, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tvalid", axis_if.TVALID, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_tlast", axis_if.TLAST, 0);
    chk("async_rst_frame_cnt", frame_cnt, 0);
    exp_q.delete();
    exp_frames = 0;
    done_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    axis_if.TREADY = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("no_done_after_reset", done_cnt, 0);
    chk("frame_cnt_after_reset", frame_cnt, 0);
    push_frames(5, 1, 1);
    exp_frames += 1;
    start_run(1'b0, 5, 1);
    chk("restart_bram_addr", bram_addr, 0);
    collect(6, 0, -1);
    chk("restart_latency", first_cyc, 2);
    check_end();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
